// File: rtl/ps2_pkg.sv
// ============================================================================
// Module      : ps2_pkg
// Description : Shared types and constants for the PS/2 scan-code receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam int DATA_BITS = 8;

    localparam logic [7:0] PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PREFIX_BRK = 8'hF0;

    localparam int ENTRY_W = 10;

    // Bit positions inside err_flags
    localparam int ERR_PARITY   = 0;
    localparam int ERR_FRAMING  = 1;
    localparam int ERR_OVERFLOW = 2;

endpackage

`default_nettype wire

// File: rtl/ps2_sync_fifo.sv
// ============================================================================
// Module      : ps2_sync_fifo
// Description : Show-ahead synchronous FIFO with occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;

    // A pop frees the slot the simultaneous push needs, so full+pop still accepts
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (w_do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(w_do_push) - CW'(w_do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ps2_rx_fifo.sv
// ============================================================================
// Module      : ps2_rx_fifo
// Description : PS/2 keyboard receiver with glitch filter, error flags and a
//               scan-code FIFO. Define PS2_BREAK_DECODE_EN to fold E0/F0
//               prefixes into the ext/brk bits of the following entry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                          inclock,
    input  logic                          reset,
    input  logic                          ps2_clock,
    input  logic                          ps2_data,
    input  logic                          rd_en,
    input  logic                          clr_err,
    output logic [ENTRY_W-1:0]            rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          ps2_key_pressed,
    output logic [7:0]                    last_data_received,
    output logic [2:0]                    err_flags
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW = $clog2(DATA_BITS);

    logic                 ps2c_s1_q, ps2c_s2_q, ps2d_s1_q, ps2d_s2_q;
    logic                 filt_clk_q, filt_clk_d;
    logic [FW-1:0]        filt_cnt_q, filt_cnt_d;
    ps2_state_e           state_q, state_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic [TW-1:0]        to_cnt_q, to_cnt_d;
    logic                 commit_q, commit_d;
    logic [7:0]           last_q, last_d;
    logic [2:0]           err_q, err_d;

    logic                 w_strobe;
    logic                 w_err_framing;
    logic                 w_err_parity;
    logic                 w_err_overflow;
    logic                 w_is_prefix;
    logic                 w_push;
    logic [ENTRY_W-1:0]   w_entry;
    logic                 w_fifo_full;

    // Glitch filter: the filtered level follows only after FILTER_LEN stable cycles
    always_comb begin
        filt_clk_d = filt_clk_q;
        filt_cnt_d = '0;
        if (ps2c_s2_q != filt_clk_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_clk_d = ps2c_s2_q;
            end else begin
                filt_cnt_d = filt_cnt_q + FW'(1);
            end
        end
    end

    assign w_strobe = filt_clk_q & ~filt_clk_d;

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        par_d         = par_q;
        commit_d      = 1'b0;
        w_err_framing = 1'b0;
        w_err_parity  = 1'b0;
        to_cnt_d      = (state_q == ST_IDLE) ? '0 : to_cnt_q + TW'(1);

        if (w_strobe) begin
            to_cnt_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (!ps2d_s2_q) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end else begin
                        w_err_framing = 1'b1;
                    end
                end
                ST_DATA: begin
                    shift_d   = {ps2d_s2_q, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_d   = ps2d_s2_q;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    w_err_framing = ~ps2d_s2_q;
                    w_err_parity  = ~(^{shift_q, par_q});
                    commit_d      = ps2d_s2_q & (^{shift_q, par_q});
                    state_d       = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE && to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            w_err_framing = 1'b1;
            state_d       = ST_IDLE;
            to_cnt_d      = '0;
        end
    end

    // The committed byte is still in shift_q: IDLE never shifts
`ifdef PS2_BREAK_DECODE_EN
    logic ext_pend_q, ext_pend_d;
    logic brk_pend_q, brk_pend_d;

    assign w_is_prefix = (shift_q == PREFIX_EXT) || (shift_q == PREFIX_BRK);
    assign w_entry     = {ext_pend_q, brk_pend_q, shift_q};

    always_comb begin
        ext_pend_d = ext_pend_q;
        brk_pend_d = brk_pend_q;
        if (commit_q) begin
            if (shift_q == PREFIX_EXT) begin
                ext_pend_d = 1'b1;
            end else if (shift_q == PREFIX_BRK) begin
                brk_pend_d = 1'b1;
            end else begin
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
            end
        end
        if (w_err_framing || w_err_parity) begin
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
        end
    end

    always_ff @(posedge inclock or posedge reset) begin
        if (reset) begin
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
        end else begin
            ext_pend_q <= ext_pend_d;
            brk_pend_q <= brk_pend_d;
        end
    end
`else
    assign w_is_prefix = 1'b0;
    assign w_entry     = {2'b00, shift_q};
`endif

    assign w_push         = commit_q & ~w_is_prefix;
    assign w_err_overflow = w_push & w_fifo_full & ~rd_en;

    always_comb begin
        last_d = commit_q ? shift_q : last_q;
        err_d  = clr_err ? 3'b000 : err_q;
        err_d[ERR_PARITY]   = err_d[ERR_PARITY]   | w_err_parity;
        err_d[ERR_FRAMING]  = err_d[ERR_FRAMING]  | w_err_framing;
        err_d[ERR_OVERFLOW] = err_d[ERR_OVERFLOW] | w_err_overflow;
    end

    always_ff @(posedge inclock or posedge reset) begin
        if (reset) begin
            ps2c_s1_q  <= 1'b1;
            ps2c_s2_q  <= 1'b1;
            ps2d_s1_q  <= 1'b1;
            ps2d_s2_q  <= 1'b1;
            filt_clk_q <= 1'b1;
            filt_cnt_q <= '0;
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            to_cnt_q   <= '0;
            commit_q   <= 1'b0;
            last_q     <= '0;
            err_q      <= '0;
        end else begin
            ps2c_s1_q  <= ps2_clock;
            ps2c_s2_q  <= ps2c_s1_q;
            ps2d_s1_q  <= ps2_data;
            ps2d_s2_q  <= ps2d_s1_q;
            filt_clk_q <= filt_clk_d;
            filt_cnt_q <= filt_cnt_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            to_cnt_q   <= to_cnt_d;
            commit_q   <= commit_d;
            last_q     <= last_d;
            err_q      <= err_d;
        end
    end

    ps2_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (inclock),
        .rst     (reset),
        .push    (w_push),
        .pop     (rd_en),
        .wr_data (w_entry),
        .rd_data (rd_data),
        .full    (w_fifo_full),
        .empty   (empty),
        .count   (count)
    );

    assign full               = w_fifo_full;
    assign ps2_key_pressed    = w_push;
    assign last_data_received = last_q;
    assign err_flags          = err_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
// ============================================================================
// Module      : tb_ps2_rx_fifo
// Description : Scoreboard bench for ps2_rx_fifo (directed PS/2 frames).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_rx_fifo;

    localparam int DEPTH = 4;
    localparam int FLEN  = 2;
    localparam int TOUT  = 200;
    localparam int HALF  = 20;

    logic       inclock   = 1'b0;
    logic       reset     = 1'b1;
    logic       ps2_clock = 1'b1;
    logic       ps2_data  = 1'b1;
    logic       rd_en     = 1'b0;
    logic       clr_err   = 1'b0;
    logic [9:0] rd_data;
    logic       empty;
    logic       full;
    logic [2:0] count;
    logic       ps2_key_pressed;
    logic [7:0] last_data_received;
    logic [2:0] err_flags;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [9:0] exp_q[$];
    bit         auto_rd  = 1'b0;
    int         kp_cnt   = 0;
    int         kp_long  = 0;
    bit         kp_prev  = 1'b0;
    int         kp0;

    always #5 inclock = ~inclock;

    ps2_rx_fifo #(
        .FIFO_DEPTH     (DEPTH),
        .FILTER_LEN     (FLEN),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .inclock            (inclock),
        .reset              (reset),
        .ps2_clock          (ps2_clock),
        .ps2_data           (ps2_data),
        .rd_en              (rd_en),
        .clr_err            (clr_err),
        .rd_data            (rd_data),
        .empty              (empty),
        .full               (full),
        .count              (count),
        .ps2_key_pressed    (ps2_key_pressed),
        .last_data_received (last_data_received),
        .err_flags          (err_flags)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Pulse counter; a pulse lasting more than one cycle is tallied in kp_long
    initial begin
        forever begin
            @(negedge inclock);
            if (ps2_key_pressed) begin
                if (kp_prev) kp_long++;
                else         kp_cnt++;
            end
            kp_prev = ps2_key_pressed;
        end
    end

    // Reader/monitor: pops the FIFO head and compares with the scoreboard
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge inclock);
            if (auto_rd && !empty && !reset) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_entry: got 0x%0h expected none", rd_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_data", {22'd0, rd_data}, {22'd0, e});
                end
                rd_en = 1'b1;
                @(negedge inclock);
                rd_en = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(negedge inclock);
        ps2_clock = 1'b0;
        repeat (HALF) @(negedge inclock);
        ps2_clock = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit((~^d) ^ par_flip);
        send_bit(1'b1);
        ps2_data = 1'b1;
        repeat (40) @(negedge inclock);
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while (!empty && n < 300) begin
            @(negedge inclock);
            n++;
        end
        chk(name, {31'd0, empty}, 32'd1);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge inclock);
        clr_err = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge inclock);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_err", {29'd0, err_flags}, 32'd0);
        chk("rst_last", {24'd0, last_data_received}, 32'd0);
        chk("rst_rd_data", {22'd0, rd_data}, 32'd0);
        chk("rst_kp", {31'd0, ps2_key_pressed}, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge inclock);

        // 1: single good byte
        kp0 = kp_cnt;
        exp_q.push_back(10'h01C);
        send_frame(8'h1C, 1'b0);
        chk("t1_count", {29'd0, count}, 32'd1);
        chk("t1_last", {24'd0, last_data_received}, 32'h1C);
        chk("t1_kp", kp_cnt - kp0, 32'd1);
        chk("t1_err", {29'd0, err_flags}, 32'd0);
        auto_rd = 1'b1;
        wait_empty("t1_empty");

        // 2: bad parity
        kp0 = kp_cnt;
        send_frame(8'h1C, 1'b1);
        chk("t2_err", {29'd0, err_flags}, 32'b001);
        chk("t2_last", {24'd0, last_data_received}, 32'h1C);
        chk("t2_kp", kp_cnt - kp0, 32'd0);
        chk("t2_empty", {31'd0, empty}, 32'd1);
        pulse_clr();
        chk("t2_clr", {29'd0, err_flags}, 32'd0);

        // 3: overflow
        auto_rd = 1'b0;
        kp0 = kp_cnt;
        for (int i = 0; i < 4; i++) exp_q.push_back(10'h011 + 10'(i));
        for (int i = 0; i < 5; i++) send_frame(8'h11 + 8'(i), 1'b0);
        chk("t3_full", {31'd0, full}, 32'd1);
        chk("t3_count", {29'd0, count}, 32'd4);
        chk("t3_err", {29'd0, err_flags}, 32'b100);
        chk("t3_kp", kp_cnt - kp0, 32'd5);
        auto_rd = 1'b1;
        wait_empty("t3_empty");
        pulse_clr();
        chk("t3_clr", {29'd0, err_flags}, 32'd0);

        // 4: timeout mid-frame, then recovery
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        ps2_data = 1'b1;
        repeat (250) @(negedge inclock);
        chk("t4_timeout_err", {29'd0, err_flags}, 32'b010);
        pulse_clr();
        exp_q.push_back(10'h02A);
        send_frame(8'h2A, 1'b0);
        wait_empty("t4_empty");
        chk("t4_err", {29'd0, err_flags}, 32'd0);
        chk("t4_last", {24'd0, last_data_received}, 32'h2A);

        // 5: prefix sequence
        kp0 = kp_cnt;
`ifdef PS2_BREAK_DECODE_EN
        exp_q.push_back(10'h374);
`else
        exp_q.push_back(10'h0E0);
        exp_q.push_back(10'h0F0);
        exp_q.push_back(10'h074);
`endif
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h74, 1'b0);
        wait_empty("t5_empty");
`ifdef PS2_BREAK_DECODE_EN
        chk("t5_kp", kp_cnt - kp0, 32'd1);
`else
        chk("t5_kp", kp_cnt - kp0, 32'd3);
`endif
        chk("t5_last", {24'd0, last_data_received}, 32'h74);
        chk("t5_err", {29'd0, err_flags}, 32'd0);

        // 6: glitch rejection, reset mid-frame, clean frame
        @(negedge inclock);
        ps2_clock = 1'b0;
        @(negedge inclock);
        ps2_clock = 1'b1;
        repeat (20) @(negedge inclock);
        chk("t6_glitch_err", {29'd0, err_flags}, 32'd0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        reset = 1'b1;
        repeat (3) @(negedge inclock);
        reset = 1'b0;
        repeat (5) @(negedge inclock);
        chk("t6_rst_empty", {31'd0, empty}, 32'd1);
        chk("t6_rst_err", {29'd0, err_flags}, 32'd0);
        chk("t6_rst_last", {24'd0, last_data_received}, 32'd0);
        exp_q.push_back(10'h055);
        send_frame(8'h55, 1'b0);
        wait_empty("t6_empty");
        chk("t6_err", {29'd0, err_flags}, 32'd0);
        chk("t6_last", {24'd0, last_data_received}, 32'h55);

        repeat (5) @(negedge inclock);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        chk("kp_single_cycle", kp_long, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Parametrised PS/2 keyboard receiver, the successor to the single-byte PS/2 interface.
- Filters and synchronises ps2_clock/ps2_data and decodes 11-bit frames (start, 8 data LSB-first, odd parity, stop).
- Detects parity, framing and timeout errors and buffers good scan codes in a show-ahead FIFO.
- Sits between the PS/2 pins and the command/keyboard logic, so the consumer can read codes at its own pace.

Parameters:
FIFO_DEPTH, 8, entries in the scan-code FIFO; power of 2, >= 2.
FILTER_LEN, 8, inclock cycles the synchronised ps2_clock must hold a new level before the filtered clock changes.
TIMEOUT_CYCLES, 100000, inclock cycles without a filtered falling edge before an in-progress frame is abandoned (2 ms at 50 MHz).

Ports:
inclock  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
ps2_clock  in  1  raw PS/2 clock pin (asynchronous).
ps2_data  in  1  raw PS/2 data pin (asynchronous).
rd_en  in  1  pop the FIFO head; ignored when empty.
clr_err  in  1  clears all sticky error flags.
rd_data  out  10  FIFO head {ext, brk, code[7:0]}; valid while empty=0.
empty  out  1  FIFO empty.
full  out  1  FIFO full.
count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
ps2_key_pressed  out  1  one-cycle pulse when an entry is pushed.
last_data_received  out  8  last byte received with good parity and framing (prefix bytes included).
err_flags  out  3  sticky {overflow, framing, parity}.

Behaviour:
- Reset values:
  - all outputs 0, except empty=1.
  - FSM IDLE.
  - filter and synchroniser registers 1 (idle-high bus).
- Reset mid-frame abandons the frame with no push and no error.
- Input path:
  - 2-flop synchroniser on both pins.
  - filtered clock toggles only after FILTER_LEN consecutive cycles at the new level.
  - a falling edge of the filtered clock is the sample strobe; data is sampled from the synchronised data line.
- FSM states and transitions (all advance on the strobe):
  - IDLE: data=0 -> DATA (bit count 0); data=1 -> set framing flag, stay IDLE.
  - DATA: shift in LSB-first; after the 8th bit -> PARITY.
  - PARITY: capture the bit; the 9 bits (data + parity) must contain an odd number of ones -> STOP.
  - STOP: data must be 1, else set framing flag. Parity failure sets the parity flag. Only if both checks pass, commit the byte. Always -> IDLE.
- Timeout: counter clears on every strobe and is held at 0 in IDLE. If it reaches TIMEOUT_CYCLES-1 outside IDLE -> set framing flag, go to IDLE.
- Commit, one cycle after the STOP strobe:
  - last_data_received <= byte.
  - if an entry is produced: push it and pulse ps2_key_pressed.
  - push while full without rd_en: entry dropped, overflow flag set, ps2_key_pressed still pulses.
  - push while full with rd_en in the same cycle: push accepted, count unchanged.
- FIFO:
  - show-ahead; rd_data shows the head combinationally from the registered pointers.
  - pointers wrap modulo FIFO_DEPTH.
  - count updates in the cycle after push or pop.
- Error flags:
  - clr_err clears all flags next cycle.
  - a flag set in the same cycle as clr_err stays set (set wins).

Optional Feature:
PS2_BREAK_DECODE_EN
- Defined:
  - byte 0xE0 sets ext_pend; byte 0xF0 sets brk_pend. Prefix bytes update last_data_received but are not pushed and do not pulse ps2_key_pressed.
  - the next non-prefix byte is pushed as {ext_pend, brk_pend, code}; both pendings then clear.
  - pendings also clear on any parity, framing or timeout error, and on reset.
- Undefined: every good byte is pushed as {2'b00, byte}.

Decomposition:
Shared package/include ps2_pkg holds:
- FSM state encoding (IDLE, DATA, PARITY, STOP).
- DATA_BITS=8.
- PREFIX_EXT=8'hE0, PREFIX_BRK=8'hF0.
- ENTRY_W=10.
- error-flag bit indices.

One natural sub-module, ps2_sync_fifo: parametrised synchronous FIFO with push/pop/full/empty/count. Synchroniser, filter and FSM stay in ps2_rx_fifo.

Test Plan:
Bench parameters: FILTER_LEN=2, TIMEOUT_CYCLES=200, FIFO_DEPTH=4, PS/2 bit period 40 cycles.
1. Frame for 0x1C, parity 0 -> rd_data=0x01C, count=1, single-cycle ps2_key_pressed, last_data_received=0x1C; rd_en -> empty=1.
2. 0x1C sent with parity 1 -> nothing pushed, err_flags=3'b001, last_data_received unchanged; clr_err -> 3'b000.
3. Five good bytes 0x11..0x15, no reads -> full=1, count=4, err_flags[2]=1; reads return 0x11..0x14 in order.
4. Start bit plus 3 data bits, then clock held high 250 cycles -> err_flags[1]=1, FSM IDLE; following frame 0x2A accepted.
5. Bytes E0, F0, 74 -> defined: one entry 0x374, one ps2_key_pressed pulse; undefined: entries 0x0E0, 0x0F0, 0x074.
6. A 1-cycle low glitch on ps2_clock is ignored (no bit sampled). reset asserted mid-frame, then a clean frame 0x55 -> rd_data=0x055, no error flags.
